core_decode_alu_ctrl: RTL

Registered decode stage that turns a 32-bit RV32I instruction word into the control bundle consumed by the execution-unit ALU: a 4-bit ALU op, operand selects, immediate and register indices. It sits between fetch and execute as one pipeline stage with valid/ready handshakes on both sides. It also supports flush for taken branches and jumps.

---
 rtl/core_decode_alu_ctrl.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/core_decode_alu_ctrl.sv
// RV32I decode stage: registers the ALU control bundle for one instruction
// behind a valid/ready handshake, with flush for redirects.
// ALU op codes: ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9.
module core_decode_alu_ctrl #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [31:0]           instr_i,
   input  logic [DATA_WIDTH-1:0] pc_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [3:0]            alu_op_o,
   output logic [1:0]            s1_sel_o,
   output logic                  s2_sel_o,
   output logic [DATA_WIDTH-1:0] imm_o,
   output logic [4:0]            rs1_o,
   output logic [4:0]            rs2_o,
   output logic [4:0]            rd_o,
   output logic                  reg_write_o,
   output logic                  mem_rd_o,
   output logic                  mem_wr_o,
   output logic                  branch_o,
   output logic                  jump_o,
   output logic [1:0]            br_cond_o,
   output logic                  illegal_o,
   output logic [DATA_WIDTH-1:0] pc_o
);

   localparam logic [3:0] ALU_OP_ADD  = 4'd0;
   localparam logic [3:0] ALU_OP_SUB  = 4'd1;
   localparam logic [3:0] ALU_OP_SLL  = 4'd2;
   localparam logic [3:0] ALU_OP_SLT  = 4'd3;
   localparam logic [3:0] ALU_OP_SLTU = 4'd4;
   localparam logic [3:0] ALU_OP_XOR  = 4'd5;
   localparam logic [3:0] ALU_OP_SRL  = 4'd6;
   localparam logic [3:0] ALU_OP_SRA  = 4'd7;
   localparam logic [3:0] ALU_OP_OR   = 4'd8;
   localparam logic [3:0] ALU_OP_AND  = 4'd9;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   typedef struct packed {
      logic [3:0]            alu_op;
      logic [1:0]            s1_sel;
      logic                  s2_sel;
      logic [DATA_WIDTH-1:0] imm;
      logic [4:0]            rs1;
      logic [4:0]            rs2;
      logic [4:0]            rd;
      logic                  reg_write;
      logic                  mem_rd;
      logic                  mem_wr;
      logic                  branch;
      logic                  jump;
      logic [1:0]            br_cond;
      logic                  illegal;
      logic [DATA_WIDTH-1:0] pc;
   } ctrl_t;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic [3:0] f3_alu_op;
   logic       valid_reg;
   ctrl_t      dec_next;
   ctrl_t      ctrl_reg;

   assign opcode = instr_i[6:0];
   assign funct3 = instr_i[14:12];
   assign funct7 = instr_i[31:25];

   assign in_ready_o = !valid_reg || out_ready_i;

   // Base ALU op selected by funct3 for register and immediate arithmetic
   always_comb begin
      f3_alu_op = ALU_OP_ADD;
      case (funct3)
         3'b000:  f3_alu_op = ALU_OP_ADD;
         3'b001:  f3_alu_op = ALU_OP_SLL;
         3'b010:  f3_alu_op = ALU_OP_SLT;
         3'b011:  f3_alu_op = ALU_OP_SLTU;
         3'b100:  f3_alu_op = ALU_OP_XOR;
         3'b101:  f3_alu_op = ALU_OP_SRL;
         3'b110:  f3_alu_op = ALU_OP_OR;
         default: f3_alu_op = ALU_OP_AND;
      endcase
   end

   // Full instruction decode into the next control bundle
   always_comb begin
      dec_next        = '0;
      dec_next.alu_op = ALU_OP_ADD;
      dec_next.rs1    = instr_i[19:15];
      dec_next.rs2    = instr_i[24:20];
      dec_next.rd     = instr_i[11:7];
      dec_next.pc     = pc_i;
      case (opcode)
         OPC_OP: begin
            dec_next.reg_write = 1'b1;
            dec_next.alu_op    = f3_alu_op;
            if (funct7 == 7'h20) begin
               if (funct3 == 3'b000)      dec_next.alu_op  = ALU_OP_SUB;
               else if (funct3 == 3'b101) dec_next.alu_op  = ALU_OP_SRA;
               else                       dec_next.illegal = 1'b1;
            end else if (funct7 != 7'h00) begin
               dec_next.illegal = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            dec_next.reg_write = 1'b1;
            dec_next.s2_sel    = 1'b1;
            dec_next.alu_op    = f3_alu_op;
            if (funct3 == 3'b001 || funct3 == 3'b101) begin
               // shifts carry only the shift amount, upper bits select SRA
               dec_next.imm = {{(DATA_WIDTH-5){1'b0}}, instr_i[24:20]};
               if (funct3 == 3'b101 && funct7 == 7'h20) dec_next.alu_op  = ALU_OP_SRA;
               else if (funct7 != 7'h00)                dec_next.illegal = 1'b1;
            end else begin
               dec_next.imm = {{(DATA_WIDTH-12){instr_i[31]}}, instr_i[31:20]};
            end
         end
         OPC_LUI, OPC_AUIPC: begin
            dec_next.reg_write = 1'b1;
            dec_next.s1_sel    = (opcode == OPC_LUI) ? 2'b10 : 2'b01;
            dec_next.s2_sel    = 1'b1;
            dec_next.imm       = {instr_i[31:12], 12'b0};
         end
         OPC_LOAD: begin
            dec_next.reg_write = 1'b1;
            dec_next.mem_rd    = 1'b1;
            dec_next.s2_sel    = 1'b1;
            dec_next.imm       = {{(DATA_WIDTH-12){instr_i[31]}}, instr_i[31:20]};
         end
         OPC_STORE: begin
            dec_next.mem_wr = 1'b1;
            dec_next.s2_sel = 1'b1;
            dec_next.imm    = {{(DATA_WIDTH-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         end
         OPC_BRANCH: begin
            dec_next.branch = 1'b1;
            dec_next.imm    = {{(DATA_WIDTH-13){instr_i[31]}}, instr_i[31], instr_i[7],
                               instr_i[30:25], instr_i[11:8], 1'b0};
            case (funct3)
               3'b000, 3'b001: begin
                  dec_next.alu_op  = ALU_OP_SUB;
                  dec_next.br_cond = {1'b0, funct3[0]};
               end
               3'b100, 3'b101: begin
                  dec_next.alu_op  = ALU_OP_SLT;
                  dec_next.br_cond = {1'b1, funct3[0]};
               end
               3'b110, 3'b111: begin
                  dec_next.alu_op  = ALU_OP_SLTU;
                  dec_next.br_cond = {1'b1, funct3[0]};
               end
               default: dec_next.illegal = 1'b1;
            endcase
         end
         OPC_JAL: begin
            dec_next.reg_write = 1'b1;
            dec_next.jump      = 1'b1;
            dec_next.s1_sel    = 2'b01;
            dec_next.s2_sel    = 1'b1;
            dec_next.imm       = {{(DATA_WIDTH-21){instr_i[31]}}, instr_i[31], instr_i[19:12],
                                  instr_i[20], instr_i[30:21], 1'b0};
         end
         OPC_JALR: begin
            dec_next.reg_write = 1'b1;
            dec_next.jump      = 1'b1;
            dec_next.s2_sel    = 1'b1;
            dec_next.imm       = {{(DATA_WIDTH-12){instr_i[31]}}, instr_i[31:20]};
            if (funct3 != 3'b000) dec_next.illegal = 1'b1;
         end
         default: dec_next.illegal = 1'b1;
      endcase
      // a trapping instruction must have no architectural side effects
      if (dec_next.illegal) begin
         dec_next.reg_write = 1'b0;
         dec_next.mem_rd    = 1'b0;
         dec_next.mem_wr    = 1'b0;
         dec_next.branch    = 1'b0;
         dec_next.jump      = 1'b0;
      end
      if (dec_next.rd == 5'd0) dec_next.reg_write = 1'b0;
   end

   // Output pipeline register: flush first, then load, then drain
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_reg <= 1'b0;
         ctrl_reg  <= '0;
      end else if (flush_i) begin
         valid_reg <= 1'b0;
      end else if (in_valid_i && in_ready_o) begin
         valid_reg <= 1'b1;
         ctrl_reg  <= dec_next;
      end else if (out_ready_i) begin
         valid_reg <= 1'b0;
      end
   end

   assign out_valid_o = valid_reg;
   assign alu_op_o    = ctrl_reg.alu_op;
   assign s1_sel_o    = ctrl_reg.s1_sel;
   assign s2_sel_o    = ctrl_reg.s2_sel;
   assign imm_o       = ctrl_reg.imm;
   assign rs1_o       = ctrl_reg.rs1;
   assign rs2_o       = ctrl_reg.rs2;
   assign rd_o        = ctrl_reg.rd;
   assign reg_write_o = ctrl_reg.reg_write;
   assign mem_rd_o    = ctrl_reg.mem_rd;
   assign mem_wr_o    = ctrl_reg.mem_wr;
   assign branch_o    = ctrl_reg.branch;
   assign jump_o      = ctrl_reg.jump;
   assign br_cond_o   = ctrl_reg.br_cond;
   assign illegal_o   = ctrl_reg.illegal;
   assign pc_o        = ctrl_reg.pc;

endmodule
